// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory arbiter: FSM encoding, latched request and read-latency bounds.
package mem_arb_pkg;

  localparam int MAX_READ_LAT = 4;
  localparam int CNT_W        = $clog2(MAX_READ_LAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        ren;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-input selector: round-robin on the last-grant pointer, or master 0 always wins when FIXED_PRIO != 0.
// Selection is combinational; the pointer moves only when the caller takes the grant.
module arb_rr2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       any,
  output logic       sel
);

  logic last;

  always_comb begin
    any = |req;
    sel = 1'b0;
    if (req[1] && !req[0]) begin
      sel = 1'b1;
    end else if (req[1] && req[0]) begin
      sel = (FIXED_PRIO != 0) ? 1'b0 : ~last;
    end
  end

  // Pointer resets to master 1 so the first tie after reset goes to master 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (take && any) begin
      last <= sel;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two masters onto one memory port: gnt one cycle after a request seen in IDLE,
// read data READ_LAT cycles after the grant; a losing master simply holds its request.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LAT   = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_ren,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_ren,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_ren,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  req_t             lat;
  req_t             m0_in, m1_in;
  logic             take, any, sel, last_wait;

  assign m0_in = '{addr: m0_addr, ren: m0_ren, wdata: m0_wdata, wmask: m0_wmask};
  assign m1_in = '{addr: m1_addr, ren: m1_ren, wdata: m1_wdata, wmask: m1_wmask};

  arb_rr2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({m1_req, m0_req}),
    .take (take),
    .any  (any),
    .sel  (sel)
  );

  assign last_wait = (state == S_WAIT) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      owner <= 1'b0;
      lat   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_ACCESS) begin
        cnt <= CNT_INIT;
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (take) begin
        owner <= sel;
        lat   <= sel ? m1_in : m0_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    mem_ren   = 1'b0;
    mem_wmask = 4'h0;
    case (state)
      S_IDLE: begin
        if (any) begin
          take      = 1'b1;
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        m0_gnt    = ~owner;
        m1_gnt    = owner;
        mem_wmask = lat.wmask;
        mem_ren   = lat.ren && (lat.wmask == 4'h0);
        state_nxt = mem_ren ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (last_wait) begin
          m0_rvalid = ~owner;
          m1_rvalid = owner;
          m0_rdata  = owner ? 32'h0 : mem_rdata;
          m1_rdata  = owner ? mem_rdata : 32'h0;
          take      = any;
          state_nxt = any ? S_ACCESS : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address and data stay on the latched request between accesses.
  assign mem_addr  = lat.addr;
  assign mem_wdata = lat.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: instance 0 = READ_LAT 1 round-robin, 1 = READ_LAT 3, 2 = fixed priority; all share stimulus.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req, m0_ren, m1_req, m1_ren;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
  logic [3:0]  m0_wmask, m1_wmask;

  logic        m0_gnt[3], m1_gnt[3], m0_rvalid[3], m1_rvalid[3], mem_ren[3];
  logic [31:0] m0_rdata[3], m1_rdata[3], mem_addr[3], mem_wdata[3];
  logic [3:0]  mem_wmask[3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(.READ_LAT(g == 1 ? 3 : 1), .FIXED_PRIO(g == 2 ? 1 : 0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_ren(m0_ren), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
      .m0_gnt(m0_gnt[g]), .m0_rvalid(m0_rvalid[g]), .m0_rdata(m0_rdata[g]),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_ren(m1_ren), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
      .m1_gnt(m1_gnt[g]), .m1_rvalid(m1_rvalid[g]), .m1_rdata(m1_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_ren(mem_ren[g]), .mem_wdata(mem_wdata[g]),
      .mem_wmask(mem_wmask[g]), .mem_rdata(mem_rdata)
    );
  end

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  ren;
    logic [3:0]  wm0, wm1;
    logic [31:0] a0, a1, wd0, wd1, mrd;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic        mren;
    logic [3:0]  mwm;
    logic [31:0] rd0, rd1, maddr, mwd;
  } vec_t;

  vec_t tv[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_req = 1'b0; m0_ren = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
    m1_req = 1'b0; m1_ren = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{2'b00, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,  32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 1'b0, 4'h0, 32'h0, 32'h0,        32'h0,   32'h0};
    tv[1]  = '{2'b01, 2'b00, 4'hF, 4'h0, 32'h100, 32'h0,  32'hDEADBEEF, 32'h0,        32'h0,        2'b00, 2'b00, 1'b0, 4'h0, 32'h0, 32'h0,        32'h0,   32'h0};
    tv[2]  = '{2'b01, 2'b00, 4'hF, 4'h0, 32'h100, 32'h0,  32'hDEADBEEF, 32'h0,        32'h0,        2'b01, 2'b00, 1'b0, 4'hF, 32'h0, 32'h0,        32'h100, 32'hDEADBEEF};
    tv[3]  = '{2'b00, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,  32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 1'b0, 4'h0, 32'h0, 32'h0,        32'h100, 32'hDEADBEEF};
    tv[4]  = '{2'b10, 2'b10, 4'h0, 4'h0, 32'h0,   32'h40, 32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 1'b0, 4'h0, 32'h0, 32'h0,        32'h100, 32'hDEADBEEF};
    tv[5]  = '{2'b10, 2'b10, 4'h0, 4'h0, 32'h0,   32'h40, 32'h0,        32'h0,        32'h0,        2'b10, 2'b00, 1'b1, 4'h0, 32'h0, 32'h0,        32'h40,  32'h0};
    tv[6]  = '{2'b00, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,  32'h0,        32'h0,        32'h12345678, 2'b00, 2'b10, 1'b0, 4'h0, 32'h0, 32'h12345678, 32'h40,  32'h0};
    tv[7]  = '{2'b00, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,  32'h0,        32'h0,        32'h12345678, 2'b00, 2'b00, 1'b0, 4'h0, 32'h0, 32'h0,        32'h40,  32'h0};
    tv[8]  = '{2'b01, 2'b01, 4'h3, 4'h0, 32'h200, 32'h0,  32'hA5A50003, 32'h0,        32'h0,        2'b00, 2'b00, 1'b0, 4'h0, 32'h0, 32'h0,        32'h40,  32'h0};
    tv[9]  = '{2'b01, 2'b01, 4'h3, 4'h0, 32'h200, 32'h0,  32'hA5A50003, 32'h0,        32'h0,        2'b01, 2'b00, 1'b0, 4'h3, 32'h0, 32'h0,        32'h200, 32'hA5A50003};
    tv[10] = '{2'b00, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,  32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 1'b0, 4'h0, 32'h0, 32'h0,        32'h200, 32'hA5A50003};
    tv[11] = '{2'b11, 2'b00, 4'hF, 4'hF, 32'h10,  32'h20, 32'h11111111, 32'h22222222, 32'h0,        2'b00, 2'b00, 1'b0, 4'h0, 32'h0, 32'h0,        32'h200, 32'hA5A50003};
    tv[12] = '{2'b11, 2'b00, 4'hF, 4'hF, 32'h10,  32'h20, 32'h11111111, 32'h22222222, 32'h0,        2'b10, 2'b00, 1'b0, 4'hF, 32'h0, 32'h0,        32'h20,  32'h22222222};
    tv[13] = '{2'b11, 2'b00, 4'hF, 4'hF, 32'h10,  32'h20, 32'h11111111, 32'h22222222, 32'h0,        2'b00, 2'b00, 1'b0, 4'h0, 32'h0, 32'h0,        32'h20,  32'h22222222};
    tv[14] = '{2'b11, 2'b00, 4'hF, 4'hF, 32'h10,  32'h20, 32'h11111111, 32'h22222222, 32'h0,        2'b01, 2'b00, 1'b0, 4'hF, 32'h0, 32'h0,        32'h10,  32'h11111111};
    tv[15] = '{2'b11, 2'b00, 4'hF, 4'hF, 32'h10,  32'h20, 32'h11111111, 32'h22222222, 32'h0,        2'b00, 2'b00, 1'b0, 4'h0, 32'h0, 32'h0,        32'h10,  32'h11111111};
    tv[16] = '{2'b11, 2'b00, 4'hF, 4'hF, 32'h10,  32'h20, 32'h11111111, 32'h22222222, 32'h0,        2'b10, 2'b00, 1'b0, 4'hF, 32'h0, 32'h0,        32'h20,  32'h22222222};
    tv[17] = '{2'b00, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,  32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 1'b0, 4'h0, 32'h0, 32'h0,        32'h20,  32'h22222222};
    tv[18] = '{2'b01, 2'b00, 4'h0, 4'h0, 32'h300, 32'h0,  32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 1'b0, 4'h0, 32'h0, 32'h0,        32'h20,  32'h22222222};
    tv[19] = '{2'b01, 2'b00, 4'h0, 4'h0, 32'h300, 32'h0,  32'h0,        32'h0,        32'h0,        2'b01, 2'b00, 1'b0, 4'h0, 32'h0, 32'h0,        32'h300, 32'h0};
    tv[20] = '{2'b00, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,  32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 1'b0, 4'h0, 32'h0, 32'h0,        32'h300, 32'h0};

    // Table: single write, single read, write with ren set, round-robin ties, no-op access.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      m0_req = tv[i].req[0]; m0_ren = tv[i].ren[0]; m0_wmask = tv[i].wm0; m0_addr = tv[i].a0; m0_wdata = tv[i].wd0;
      m1_req = tv[i].req[1]; m1_ren = tv[i].ren[1]; m1_wmask = tv[i].wm1; m1_addr = tv[i].a1; m1_wdata = tv[i].wd1;
      mem_rdata = tv[i].mrd;
      @(negedge clk);
      chk($sformatf("row%0d m0_gnt", i),    m0_gnt[0],    tv[i].gnt[0]);
      chk($sformatf("row%0d m1_gnt", i),    m1_gnt[0],    tv[i].gnt[1]);
      chk($sformatf("row%0d m0_rvalid", i), m0_rvalid[0], tv[i].rv[0]);
      chk($sformatf("row%0d m1_rvalid", i), m1_rvalid[0], tv[i].rv[1]);
      chk($sformatf("row%0d mem_ren", i),   mem_ren[0],   tv[i].mren);
      chk($sformatf("row%0d mem_wmask", i), mem_wmask[0], tv[i].mwm);
      chk($sformatf("row%0d m0_rdata", i),  m0_rdata[0],  tv[i].rd0);
      chk($sformatf("row%0d m1_rdata", i),  m1_rdata[0],  tv[i].rd1);
      chk($sformatf("row%0d mem_addr", i),  mem_addr[0],  tv[i].maddr);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata[0], tv[i].mwd);
      next_cycle();
    end

    // READ_LAT=3: back-to-back reads, m0 wins the first tie after reset.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      m0_req = (c <= 1); m0_ren = 1'b1; m0_addr = 32'h80;
      m1_req = (c <= 5); m1_ren = 1'b1; m1_addr = 32'h90;
      mem_rdata = 32'hC0DE0000 | c;
      @(negedge clk);
      chk($sformatf("rl3 c%0d m0_gnt", c),    m0_gnt[1],    (c == 1));
      chk($sformatf("rl3 c%0d m1_gnt", c),    m1_gnt[1],    (c == 5));
      chk($sformatf("rl3 c%0d m0_rvalid", c), m0_rvalid[1], (c == 4));
      chk($sformatf("rl3 c%0d m1_rvalid", c), m1_rvalid[1], (c == 8));
      chk($sformatf("rl3 c%0d m0_rdata", c),  m0_rdata[1],  (c == 4) ? (32'hC0DE0000 | c) : 32'h0);
      chk($sformatf("rl3 c%0d m1_rdata", c),  m1_rdata[1],  (c == 8) ? (32'hC0DE0000 | c) : 32'h0);
      chk($sformatf("rl3 c%0d mem_ren", c),   mem_ren[1],   (c == 1 || c == 5));
      next_cycle();
    end

    // Both masters hold write requests: alternation vs fixed priority.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      m0_req = 1'b1; m0_wmask = 4'hF; m0_addr = 32'h10;
      m1_req = 1'b1; m1_wmask = 4'hF; m1_addr = 32'h20;
      @(negedge clk);
      chk($sformatf("rr c%0d m0_gnt", c),  m0_gnt[0], (c == 1 || c == 5));
      chk($sformatf("rr c%0d m1_gnt", c),  m1_gnt[0], (c == 3 || c == 7));
      chk($sformatf("fix c%0d m0_gnt", c), m0_gnt[2], (c % 2 == 1));
      chk($sformatf("fix c%0d m1_gnt", c), m1_gnt[2], 1'b0);
      next_cycle();
    end

    // Reset in the middle of a READ_LAT=3 read from m0.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      m0_req = (c <= 1); m0_ren = 1'b1; m0_addr = 32'h80; m0_wdata = 32'h5555AAAA;
      mem_rdata = 32'hFEEDF00D;
      @(negedge clk);
      chk($sformatf("rst c%0d m0_gnt", c), m0_gnt[1], (c == 1));
      if (c < 2) next_cycle();
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rst mem_addr",  mem_addr[1],  32'h0);
    chk("rst mem_wdata", mem_wdata[1], 32'h0);
    chk("rst mem_ren",   mem_ren[1],   1'b0);
    chk("rst mem_wmask", mem_wmask[1], 4'h0);
    chk("rst m0_rvalid", m0_rvalid[1], 1'b0);
    chk("rst m0_rdata",  m0_rdata[1],  32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m0_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("post c%0d m0_rvalid", c), m0_rvalid[1], 1'b0);
      chk($sformatf("post c%0d m1_rvalid", c), m1_rvalid[1], 1'b0);
      next_cycle();
    end
    for (int c = 0; c < 2; c++) begin
      m0_req = 1'b1; m0_ren = 1'b0; m0_wmask = 4'hF;
      m1_req = 1'b1; m1_ren = 1'b0; m1_wmask = 4'hF;
      @(negedge clk);
      chk($sformatf("tie c%0d m0_gnt", c), m0_gnt[1], (c == 1));
      chk($sformatf("tie c%0d m1_gnt", c), m1_gnt[1], 1'b0);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
